// File: rtl/lcd_cmd_fifo.sv
// ---------------------------------------------------------------------------
// lcd_cmd_fifo
//
// Circular queue of {cmd, data} words between the user front end and the
// LCD timing FSM. A rising edge on `en` enqueues one word. A falling edge on
// `busy` releases the next word, but only once `init_done` is high. The head
// entry is presented on registered outputs.
//
// Parameters
//   DATA_W    width of the LCD data field
//   DEPTH     number of entries (>= 2, need not be a power of two)
//   AFULL_LVL buf_afull asserts when the occupancy is >= this level (1..DEPTH)
//   CNT_W     width of the occupancy count (derived, leave at default)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   data, cmd  word to enqueue (cmd = 1 marks a command)
//   en         enqueue request (level; edge-detected here)
//   init_done  LCD initialisation complete; gates dequeue only
//   busy       LCD FSM busy; a falling edge requests a dequeue
//   flush      synchronous clear of contents and overflow flag
//   buf_data   head entry data (registered)
//   buf_cmd    head entry cmd (registered)
//   buf_en     registered, high while the queue is non-empty
//   buf_full   occupancy == DEPTH
//   buf_afull  occupancy >= AFULL_LVL
//   buf_count  current occupancy, 0..DEPTH
//   buf_ovf    sticky, set when an enqueue is dropped on a full queue
// ---------------------------------------------------------------------------
module lcd_cmd_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 31,
  parameter int AFULL_LVL = 28,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              cmd,
  input  logic              en,
  input  logic              init_done,
  input  logic              busy,
  input  logic              flush,
  output logic [DATA_W-1:0] buf_data,
  output logic              buf_cmd,
  output logic              buf_en,
  output logic              buf_full,
  output logic              buf_afull,
  output logic [CNT_W-1:0]  buf_count,
  output logic              buf_ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = DATA_W + 1;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

  // Storage, one {cmd, data} word per entry
  logic [ENT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             en_d, busy_d;

  logic             push, pop_req, pop, is_full;
  logic             wr_en, ovf_next;
  logic [PTR_W-1:0] rd_next, wr_next;
  logic [CNT_W-1:0] cnt_next;
  logic [ENT_W-1:0] wr_ent, head_next;

  // Pointers wrap explicitly at DEPTH-1 so any depth works, not just 2^n.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Edge detection, then the per-cycle queue update in priority order:
  // flush, simultaneous push/pop, push, pop. A push together with a pop
  // keeps the count unchanged, so it is allowed even when the queue is full:
  // the slot freed by the pop takes the new word.
  always_comb begin
    push      = en & ~en_d;
    pop_req   = ~busy & busy_d & init_done;
    pop       = pop_req & (count != '0);
    is_full   = (count == FULL_CNT);
    wr_ent    = {cmd, data};

    rd_next   = rd_ptr;
    wr_next   = wr_ptr;
    cnt_next  = count;
    ovf_next  = buf_ovf;
    wr_en     = 1'b0;

    if (flush) begin
      rd_next  = '0;
      wr_next  = '0;
      cnt_next = '0;
      ovf_next = 1'b0;
    end else if (push && pop) begin
      wr_en   = 1'b1;
      wr_next = ptr_inc(wr_ptr);
      rd_next = ptr_inc(rd_ptr);
    end else if (push && !is_full) begin
      wr_en    = 1'b1;
      wr_next  = ptr_inc(wr_ptr);
      cnt_next = count + CNT_W'(1);
    end else if (push) begin
      ovf_next = 1'b1;
    end else if (pop) begin
      rd_next  = ptr_inc(rd_ptr);
      cnt_next = count - CNT_W'(1);
    end

    // When the word being written this cycle lands on the next head slot
    // (push into an empty queue, or push+pop with one entry) it is forwarded
    // so the outputs never show the slot's old contents.
    if (wr_en && (wr_ptr == rd_next)) begin
      head_next = wr_ent;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // Storage array, cleared on reset, written on an accepted push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  // Control state and registered head outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      en_d     <= 1'b0;
      busy_d   <= 1'b0;
      buf_ovf  <= 1'b0;
      buf_data <= '0;
      buf_cmd  <= 1'b0;
      buf_en   <= 1'b0;
    end else begin
      rd_ptr   <= rd_next;
      wr_ptr   <= wr_next;
      count    <= cnt_next;
      en_d     <= en;
      busy_d   <= busy;
      buf_ovf  <= ovf_next;
      buf_cmd  <= head_next[ENT_W-1];
      buf_data <= head_next[DATA_W-1:0];
      buf_en   <= (cnt_next != '0);
    end
  end

  assign buf_count = count;
  assign buf_full  = (count == FULL_CNT);
  assign buf_afull = (count >= AFULL_CNT);

endmodule

// File: tb/tb_lcd_cmd_fifo.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_fifo
//
// Self-checking bench for lcd_cmd_fifo, built with DEPTH = 4 and
// AFULL_LVL = 3 so that full, wrap and almost-full are all reachable in a
// few cycles. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that point, reflecting the state after the edge.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_fifo;

  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int AFL = 3;
  localparam int CW  = $clog2(DEP + 1);

  logic          clk;
  logic          rst;
  logic [DW-1:0] data;
  logic          cmd;
  logic          en;
  logic          init_done;
  logic          busy;
  logic          flush;
  logic [DW-1:0] buf_data;
  logic          buf_cmd;
  logic          buf_en;
  logic          buf_full;
  logic          buf_afull;
  logic [CW-1:0] buf_count;
  logic          buf_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // One table row: inputs for a cycle, then the outputs expected after it
  typedef struct {
    logic          en;
    logic          cmd;
    logic [DW-1:0] data;
    logic          busy;
    logic          e_en;
    logic          e_cmd;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cnt;
    logic          e_full;
    logic          e_afull;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[$];

  lcd_cmd_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .AFULL_LVL(AFL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .cmd      (cmd),
    .en       (en),
    .init_done(init_done),
    .busy     (busy),
    .flush    (flush),
    .buf_data (buf_data),
    .buf_cmd  (buf_cmd),
    .buf_en   (buf_en),
    .buf_full (buf_full),
    .buf_afull(buf_afull),
    .buf_count(buf_count),
    .buf_ovf  (buf_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic i_en, input logic i_cmd,
                              input logic [DW-1:0] i_data, input logic i_busy,
                              input logic x_en, input logic x_cmd,
                              input logic [DW-1:0] x_data, input logic [CW-1:0] x_cnt,
                              input logic x_full, input logic x_afull,
                              input logic x_ovf);
    vec_t v;
    v.en = i_en; v.cmd = i_cmd; v.data = i_data; v.busy = i_busy;
    v.e_en = x_en; v.e_cmd = x_cmd; v.e_data = x_data; v.e_cnt = x_cnt;
    v.e_full = x_full; v.e_afull = x_afull; v.e_ovf = x_ovf;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and return just after the next rising edge
  task automatic step(input logic f, input logic e, input logic c,
                      input logic [DW-1:0] d, input logic b);
    flush = f; en = e; cmd = c; data = d; busy = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic c, input logic [DW-1:0] d);
    step(1'b0, 1'b1, c, d, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_pop();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v);
    init_done = 1'b1;
    step(1'b0, v.en, v.cmd, v.data, v.busy);
  endtask

  task automatic check_row(input int idx, input vec_t v);
    logic [15:0] act, exp;
    exp = {v.e_en, v.e_en ? v.e_cmd : 1'b0, v.e_en ? v.e_data : 8'h00,
           v.e_cnt, v.e_full, v.e_afull, v.e_ovf};
    act = {buf_en, v.e_en ? buf_cmd : 1'b0, v.e_en ? buf_data : 8'h00,
           buf_count, buf_full, buf_afull, buf_ovf};
    checkOutput($sformatf("row%0d", idx), {16'h0, act}, {16'h0, exp});
  endtask

  function automatic logic [15:0] all_outs();
    return {buf_en, buf_cmd, buf_data, buf_count, buf_full, buf_afull, buf_ovf};
  endfunction

  initial begin
    // Columns: en cmd data busy | buf_en cmd data count full afull ovf
    // Order and latency of three entries, then drain
    tbl.push_back(mk(1,1,8'h38,0, 1,1,8'h38,3'd1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0, 1,1,8'h38,3'd1,0,0,0));
    tbl.push_back(mk(1,0,8'h41,0, 1,1,8'h38,3'd2,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0, 1,1,8'h38,3'd2,0,0,0));
    tbl.push_back(mk(1,0,8'h42,0, 1,1,8'h38,3'd3,0,1,0));
    tbl.push_back(mk(0,0,8'h00,1, 1,1,8'h38,3'd3,0,1,0));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h41,3'd2,0,0,0));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h41,3'd2,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h42,3'd1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h42,3'd1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0, 0,0,8'h00,3'd0,0,0,0));
    // Fill to full, drop a fifth push, then pop 2 / push 2 across the wrap
    tbl.push_back(mk(1,0,8'h01,0, 1,0,8'h01,3'd1,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h01,3'd1,0,0,0));
    tbl.push_back(mk(1,0,8'h02,0, 1,0,8'h01,3'd2,0,0,0));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h01,3'd2,0,0,0));
    tbl.push_back(mk(1,0,8'h03,0, 1,0,8'h01,3'd3,0,1,0));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h01,3'd3,0,1,0));
    tbl.push_back(mk(1,0,8'h04,0, 1,0,8'h01,3'd4,1,1,0));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h01,3'd4,1,1,0));
    tbl.push_back(mk(1,0,8'h05,0, 1,0,8'h01,3'd4,1,1,1));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h01,3'd4,1,1,1));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h02,3'd3,0,1,1));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h02,3'd3,0,1,1));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h03,3'd2,0,0,1));
    tbl.push_back(mk(1,0,8'h06,0, 1,0,8'h03,3'd3,0,1,1));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h03,3'd3,0,1,1));
    tbl.push_back(mk(1,0,8'h07,0, 1,0,8'h03,3'd4,1,1,1));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h03,3'd4,1,1,1));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h04,3'd3,0,1,1));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h04,3'd3,0,1,1));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h06,3'd2,0,0,1));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h06,3'd2,0,0,1));
    tbl.push_back(mk(0,0,8'h00,0, 1,0,8'h07,3'd1,0,0,1));
    tbl.push_back(mk(0,0,8'h00,1, 1,0,8'h07,3'd1,0,0,1));
    tbl.push_back(mk(0,0,8'h00,0, 0,0,8'h00,3'd0,0,0,1));

    // Power-on reset
    rst = 1'b0; flush = 1'b0; en = 1'b0; cmd = 1'b0; data = '0;
    busy = 1'b0; init_done = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 checkOutput("reset_state", {16'h0, all_outs()}, 32'h0);

    // Asynchronous reset in the middle of a non-empty queue
    do_push(1'b1, 8'hAA);
    do_push(1'b0, 8'hBB);
    do_push(1'b0, 8'hCC);
    checkOutput("pre_reset_count", {29'h0, buf_count}, 32'd3);
    #2 rst = 1'b0;
    #1 checkOutput("async_reset_outs", {16'h0, all_outs()}, 32'h0);
    checkOutput("async_reset_count", {29'h0, buf_count}, 32'd0);
    #2 rst = 1'b1;

    // Table-driven ordering, full, overflow and wrap
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      check_row(i, tbl[i]);
    end

    // Full queue: push and pop in the same cycle
    do_push(1'b0, 8'hA1);
    do_push(1'b0, 8'hA2);
    do_push(1'b0, 8'hA3);
    do_push(1'b0, 8'hA4);
    checkOutput("sim_full_fill", {29'h0, buf_count}, 32'd4);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
    checkOutput("sim_full_count", {29'h0, buf_count}, 32'd4);
    checkOutput("sim_full_head", {24'h0, buf_data}, 32'hA2);
    checkOutput("sim_full_flag", {31'h0, buf_full}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_pop();
    checkOutput("sim_full_out2", {24'h0, buf_data}, 32'hA3);
    do_pop();
    checkOutput("sim_full_out3", {24'h0, buf_data}, 32'hA4);
    do_pop();
    checkOutput("sim_full_out4", {24'h0, buf_data}, 32'hA5);
    checkOutput("sim_full_cnt4", {29'h0, buf_count}, 32'd1);
    do_pop();
    checkOutput("sim_full_drain", {30'h0, buf_en, buf_count != 3'd0}, 32'd0);

    // Empty queue: push and busy falling edge together, pop is ignored
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);
    checkOutput("sim_empty_count", {29'h0, buf_count}, 32'd1);
    checkOutput("sim_empty_head", {22'h0, buf_en, buf_cmd, buf_data}, 32'h35A);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    do_pop();
    checkOutput("sim_empty_drain", {29'h0, buf_count}, 32'd0);

    // Dequeue gated by init_done; busy edges while low are lost
    init_done = 1'b0;
    do_push(1'b0, 8'h11);
    do_push(1'b0, 8'h22);
    for (int k = 0; k < 5; k++) do_pop();
    checkOutput("gate_count", {29'h0, buf_count}, 32'd2);
    checkOutput("gate_head", {24'h0, buf_data}, 32'h11);
    init_done = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("gate_no_defer", {29'h0, buf_count}, 32'd2);
    checkOutput("afull_below", {31'h0, buf_afull}, 32'd0);

    // en held high for ten cycles gives exactly one push
    step(1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
    checkOutput("afull_rise", {31'h0, buf_afull}, 32'd1);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
    checkOutput("en_held_count", {29'h0, buf_count}, 32'd3);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Flush together with a push
    checkOutput("flush_pre_ovf", {31'h0, buf_ovf}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'h44, 1'b0);
    checkOutput("flush_count", {29'h0, buf_count}, 32'd0);
    checkOutput("flush_ovf", {31'h0, buf_ovf}, 32'd0);
    checkOutput("flush_en", {31'h0, buf_en}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("flush_discard", {29'h0, buf_count}, 32'd0);
    do_push(1'b1, 8'h55);
    checkOutput("post_flush_head", {22'h0, buf_en, buf_cmd, buf_data}, 32'h355);
    checkOutput("post_flush_count", {29'h0, buf_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
